// File: rtl/buffer_seq_pkg.sv
// rtl/buffer_seq_pkg.sv - shared state enum, default sizing and slot-index type for buffer_sequencer
package buffer_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int SLOTS_DEFAULT       = 10;
    localparam int SLOT_CYCLES_DEFAULT = 4;

    typedef logic [3:0] slot_idx_t;

endpackage

// File: rtl/slot_timer.sv
// rtl/slot_timer.sv - per-slot cycle counter; slot_end marks the last cycle of a slot
module slot_timer #(
    parameter int SLOT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic slot_end
);

    localparam logic [7:0] LAST = 8'(SLOT_CYCLES - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable) begin
            count_d = (count_q == LAST) ? 8'd0 : count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign slot_end = (count_q == LAST);

endmodule

// File: rtl/buffer_sequencer.sv
// rtl/buffer_sequencer.sv - fill/drain slot sequencer; BUFFER_SEQUENCER_AUTO_DRAIN_EN makes FULL a one-cycle pass-through
module buffer_sequencer
    import buffer_seq_pkg::*;
#(
    parameter int SLOT_CYCLES = SLOT_CYCLES_DEFAULT,
    parameter int SLOTS       = SLOTS_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       drain_req,
    input  logic [7:0] sample_in,
    output logic [3:0] percent,
    output logic       emptyBuffer,
    output logic [7:0] sample_out,
    output logic       full,
    output logic       busy,
    output logic       done
);

    localparam slot_idx_t SLOT_LAST = slot_idx_t'(SLOTS - 1);

    state_t    state_q, state_d;
    slot_idx_t percent_q, percent_d;
    logic      empty_q, empty_d;
    logic [7:0] sample_q, sample_d;
    logic      full_q, full_d;
    logic      busy_q, busy_d;
    logic      done_q, done_d;
    logic      slot_end;
    logic      go_drain;

`ifdef BUFFER_SEQUENCER_AUTO_DRAIN_EN
    logic unused_drain_req;
    assign unused_drain_req = drain_req;
    assign go_drain = 1'b1;
`else
    assign go_drain = drain_req;
`endif

    // Timer restarts from zero on every state change so each state begins on a slot boundary.
    slot_timer #(.SLOT_CYCLES(SLOT_CYCLES)) u_slot_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_d != state_q),
        .enable   ((state_q == FILL) || (state_q == DRAIN)),
        .slot_end (slot_end)
    );

    always_comb begin
        state_d   = state_q;
        percent_d = percent_q;
        empty_d   = empty_q;
        sample_d  = sample_q;
        full_d    = full_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FILL;
                    percent_d = '0;
                    empty_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            FILL: begin
                sample_d = sample_in;
                if (slot_end) begin
                    if (percent_q == SLOT_LAST) begin
                        state_d = FULL;
                        full_d  = 1'b1;
                    end else begin
                        percent_d = percent_q + slot_idx_t'(1);
                    end
                end
            end
            FULL: begin
                if (go_drain) begin
                    state_d   = DRAIN;
                    percent_d = '0;
                    empty_d   = 1'b1;
                    full_d    = 1'b0;
                end
            end
            DRAIN: begin
                if (slot_end) begin
                    if (percent_q == SLOT_LAST) begin
                        state_d   = IDLE;
                        percent_d = '0;
                        empty_d   = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        percent_d = percent_q + slot_idx_t'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            percent_q <= '0;
            empty_q   <= 1'b0;
            sample_q  <= 8'd0;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            percent_q <= percent_d;
            empty_q   <= empty_d;
            sample_q  <= sample_d;
            full_q    <= full_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign percent     = percent_q;
    assign emptyBuffer = empty_q;
    assign sample_out  = sample_q;
    assign full        = full_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_buffer_sequencer.sv
// tb/tb_buffer_sequencer.sv - scoreboard bench for buffer_sequencer (SLOT_CYCLES=4, SLOTS=10)
module tb_buffer_sequencer;

    typedef struct packed {
        logic [3:0] percent;
        logic       empty;
        logic       full;
        logic       busy;
        logic       done;
        logic [7:0] sout;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       start;
    logic       drain_req;
    logic [7:0] sample_in;
    logic [3:0] percent;
    logic       emptyBuffer;
    logic [7:0] sample_out;
    logic       full;
    logic       busy;
    logic       done;

    exp_t       exp_q[$];
    int         checks;
    int         errors;
    int         cycle_no;
    logic [7:0] sout_exp;

    buffer_sequencer #(.SLOT_CYCLES(4), .SLOTS(10)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .drain_req   (drain_req),
        .sample_in   (sample_in),
        .percent     (percent),
        .emptyBuffer (emptyBuffer),
        .sample_out  (sample_out),
        .full        (full),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t mk(input int p, input logic e, input logic f,
                                input logic b, input logic d, input logic [7:0] s);
        exp_t x;
        x.percent = 4'(p);
        x.empty   = e;
        x.full    = f;
        x.busy    = b;
        x.done    = d;
        x.sout    = s;
        return x;
    endfunction

    // Drive one cycle of inputs, then queue what the outputs must be after the edge.
    task automatic cyc(input logic rst, input logic st, input logic dr,
                       input logic [7:0] si, input exp_t e);
        reset     = rst;
        start     = st;
        drain_req = dr;
        sample_in = si;
        @(posedge clock);
        #1;
        exp_q.push_back(e);
    endtask

    // Start pulse from IDLE, then FILL cycles k=1..40 with sample_in=k; optional stop in FILL cycle stop_at.
    task automatic do_fill(input logic noise, input int stop_at);
        cyc(0, 1, 0, 8'd0, mk(0, 0, 0, 1, 0, sout_exp));
        for (int k = 1; k <= 40; k++) begin
            if (k == stop_at) return;
            sout_exp = 8'(k);
            cyc(0, noise && (k == 5 || k == 17), noise && (k == 10), 8'(k),
                (k < 40) ? mk(k / 4, 0, 0, 1, 0, sout_exp) : mk(9, 0, 1, 1, 0, sout_exp));
        end
    endtask

    // Caller has just entered DRAIN cycle 1.
    task automatic do_drain(input logic hold_start);
        for (int j = 1; j <= 40; j++) begin
            cyc(0, hold_start || (j == 10), (j == 20), 8'h3C,
                (j < 40) ? mk(j / 4, 1, 0, 1, 0, sout_exp) : mk(0, 0, 0, 0, 1, sout_exp));
        end
        if (hold_start) cyc(0, 1, 0, 8'd0, mk(0, 0, 0, 1, 0, sout_exp));
        else            cyc(0, 0, 0, 8'd0, mk(0, 0, 0, 0, 0, sout_exp));
    endtask

    initial begin : monitor
        exp_t want;
        exp_t got;
        cycle_no = 0;
        forever begin
            @(negedge clock);
            cycle_no++;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = {percent, emptyBuffer, full, busy, done, sample_out};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs t=%0t cyc=%0d got p=%0d e=%b f=%b b=%b d=%b s=%0d want p=%0d e=%b f=%b b=%b d=%b s=%0d",
                             $time, cycle_no, got.percent, got.empty, got.full, got.busy, got.done, got.sout,
                             want.percent, want.empty, want.full, want.busy, want.done, want.sout);
                end
            end
        end
    end

    initial begin : stimulus
        checks    = 0;
        errors    = 0;
        sout_exp  = 8'd0;
        reset     = 1'b1;
        start     = 1'b0;
        drain_req = 1'b0;
        sample_in = 8'd0;

        cyc(1, 0, 0, 8'h55, mk(0, 0, 0, 0, 0, 8'd0));
        cyc(1, 1, 1, 8'h55, mk(0, 0, 0, 0, 0, 8'd0));
        cyc(0, 0, 1, 8'h55, mk(0, 0, 0, 0, 0, 8'd0));

`ifdef BUFFER_SEQUENCER_AUTO_DRAIN_EN
        do_fill(1, 0);
        cyc(0, 0, 0, 8'h11, mk(0, 1, 0, 1, 0, sout_exp));
        do_drain(0);
        do_fill(0, 0);
        cyc(0, 1, 0, 8'h11, mk(0, 1, 0, 1, 0, sout_exp));
        do_drain(1);
        sout_exp = 8'd0;
        cyc(1, 0, 0, 8'd0, mk(0, 0, 0, 0, 0, 8'd0));
`else
        do_fill(0, 0);
        for (int i = 1; i <= 19; i++) begin
            cyc(0, (i == 3), 0, 8'hA5, mk(9, 0, 1, 1, 0, sout_exp));
        end
        cyc(0, 0, 1, 8'hA5, mk(0, 1, 0, 1, 0, sout_exp));
        do_drain(0);

        do_fill(1, 0);
        cyc(0, 0, 0, 8'h00, mk(9, 0, 1, 1, 0, sout_exp));
        sout_exp = 8'd0;
        cyc(1, 0, 0, 8'h00, mk(0, 0, 0, 0, 0, 8'd0));

        do_fill(0, 26);
        sout_exp = 8'd0;
        cyc(1, 1, 1, 8'h77, mk(0, 0, 0, 0, 0, 8'd0));
        cyc(0, 0, 0, 8'h00, mk(0, 0, 0, 0, 0, 8'd0));

        do_fill(0, 0);
        cyc(0, 1, 1, 8'h00, mk(0, 1, 0, 1, 0, sout_exp));
        do_drain(1);
        sout_exp = 8'd0;
        cyc(1, 0, 0, 8'd0, mk(0, 0, 0, 0, 0, 8'd0));
`endif

        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain leftover=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
